run_stuff_tx: RTL and testbench
===============================

# run_stuff_tx

Serial frame transmitter for the single-bit run-length-framed line. It accepts parallel words on a valid/ready handshake and emits each one as a frame: a preamble run of ones, a zero delimiter, then an LSB-first payload. The payload is zero-stuffed so it never contains a run long enough to be mistaken for a preamble. It drives the line that the consecutive-ones sequence detectors on the receive side monitor.

## Interface
- DATA_W, 8, payload width in bits (>=1)
- PRE_ONES, 3, preamble length in consecutive ones (>=2); stuffing threshold is PRE_ONES-1
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- bit_en  input  1  bit-rate strobe; the FSM advances only on clk edges where bit_en=1
- in_valid  input  1  word available
- in_data  input  DATA_W  word; sampled only on handshake
- in_ready  output  1  (state==IDLE) && bit_en, combinational
- tx_bit  output  1  serial line; Moore output decoded from state
- tx_active  output  1  state != IDLE
- frame_done  output  1  registered one-clk pulse when a frame completes

## Operation
- States (tx_state_t): IDLE, PRE, DELIM, DATA, STUFF.
- tx_bit per state:
  - IDLE: 0
  - PRE: 1
  - DELIM: 0
  - DATA: shreg[0]
  - STUFF: 0
- All transitions below occur only on edges where bit_en=1. With bit_en=0 all state, counters and outputs hold.
- IDLE: on in_valid && in_ready, latch shreg <= in_data, pre_cnt <= 0, then go to PRE.
- PRE: pre_cnt increments. When pre_cnt == PRE_ONES-1, go to DELIM.
- DELIM: clear bit_idx and run, then go to DATA.
- DATA, bit b = shreg[0]:
  - Shift shreg right and increment bit_idx.
  - run <= b ? run+1 : 0.
  - If b==1 and run+1 == PRE_ONES-1, go to STUFF. This applies to the last bit too, so a trailing stuff bit is always sent.
  - Otherwise, if bit_idx == DATA_W-1, go to IDLE.
  - Otherwise stay in DATA.
- STUFF: run <= 0. Go to DATA if bits remain, else go to IDLE.
- frame_done is set for the cycle following each DATA->IDLE or STUFF->IDLE transition.
- Guarantee: the payload never carries more than PRE_ONES-1 consecutive ones, and the preamble is always followed by exactly one 0.
- Frame length in bit periods: PRE_ONES + 1 + DATA_W + (number of stuffed zeros).
- Counter widths: pre_cnt and run use $clog2(PRE_ONES)+1 bits; bit_idx uses $clog2(DATA_W)+1 bits. No wrap is permitted.

## Timing
- Reset values: state IDLE, tx_bit 0, tx_active 0, frame_done 0. in_ready then follows bit_en.
- Handshake at bit_en cycle t: tx_bit=1 and tx_active=1 from cycle t+1.
- Each bit holds from one bit_en edge to the next.
- Minimum inter-frame gap is one full bit period of 0, because IDLE is entered on a bit_en edge and can be left only on a later one.
- With bit_en held at 1 and in_valid held at 1, frames are back-to-back with exactly one idle bit between them.
- Reset mid-frame aborts the frame immediately (asynchronous). tx_bit drops to 0 and no frame_done is issued. The word in flight is lost.
- in_valid may drop without a handshake; nothing is latched.
- A handshake is impossible while tx_active=1.

## Structure
- Package run_stuff_pkg contains tx_state_t (enum logic [2:0]) and the default constants DATA_W_DEF=8 and PRE_ONES_DEF=3. Receive-side blocks reuse the same package.
- Single module with no sub-module: one always_ff for state and datapath registers, one always_comb for next-state and tx_bit.

## Test plan
- Reset, then in_valid=0 with bit_en=1 for 10 clks -> tx_bit=0, tx_active=0, in_ready=1, frame_done never set.
- DATA_W=8, PRE_ONES=3, bit_en=1, send 8'h00 -> tx_bit 1,1,1,0 then eight 0s (12 bits); frame_done pulses once on the cycle after the last bit.
- Send 8'hFF -> 1,1,1,0 then 1,1,0,1,1,0,1,1,0,1,1,0 (16 bits, four stuffed zeros including a trailing one).
- Send 8'hB6 -> 1,1,1,0 then 0,1,1,0,0,1,1,0,0,1 (14 bits); then 8'h01 back-to-back -> exactly one idle 0 between frames.
- bit_en asserted every 4th clk, send 8'hA5 -> each bit lasts exactly 4 clks, in_ready is high only on bit_en cycles, bit sequence matches the bit_en=1 case.
- Assert rst_n low during payload bit 3 of 8'hFF -> tx_bit=0 and tx_active=0 immediately; the next accepted frame starts with a clean 3-bit preamble.

Source files
------------

// File: rtl/run_stuff_pkg.sv
// Shared types and defaults for the run-length-framed serial line (TX and RX sides).
package run_stuff_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        DELIM = 3'd2,
        DATA  = 3'd3,
        STUFF = 3'd4
    } tx_state_t;

    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned PRE_ONES_DEF = 3;

endpackage

// File: rtl/run_stuff_tx.sv
// Frame transmitter: preamble of ones, one zero delimiter, then a zero-stuffed LSB-first payload.
module run_stuff_tx
    import run_stuff_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned PRE_ONES = PRE_ONES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_active,
    output logic              frame_done
);

    localparam int unsigned CW = $clog2(PRE_ONES) + 1;
    localparam int unsigned IW = $clog2(DATA_W) + 1;

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     pre_cnt_q, pre_cnt_d;
    logic [CW-1:0]     run_q, run_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d;
    logic              frame_done_q, frame_done_d;
    logic [CW-1:0]     run_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            pre_cnt_q    <= '0;
            run_q        <= '0;
            bit_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            pre_cnt_q    <= pre_cnt_d;
            run_q        <= run_d;
            bit_idx_q    <= bit_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        pre_cnt_d    = pre_cnt_q;
        run_d        = run_q;
        bit_idx_d    = bit_idx_q;
        frame_done_d = 1'b0;
        run_inc      = run_q + CW'(1);
        in_ready     = (state_q == IDLE) && bit_en;

        case (state_q)
            PRE:     tx_bit = 1'b1;
            DATA:    tx_bit = shreg_q[0];
            default: tx_bit = 1'b0;
        endcase

        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shreg_d   = in_data;
                        pre_cnt_d = '0;
                        state_d   = PRE;
                    end
                end
                PRE: begin
                    pre_cnt_d = pre_cnt_q + CW'(1);
                    if (pre_cnt_q == CW'(PRE_ONES - 1)) begin
                        state_d = DELIM;
                    end
                end
                DELIM: begin
                    bit_idx_d = '0;
                    run_d     = '0;
                    state_d   = DATA;
                end
                DATA: begin
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = bit_idx_q + IW'(1);
                    run_d     = shreg_q[0] ? run_inc : '0;
                    // A stuff zero follows even the last payload bit when the run hits threshold
                    if (shreg_q[0] && (run_inc == CW'(PRE_ONES - 1))) begin
                        state_d = STUFF;
                    end else if (bit_idx_q == IW'(DATA_W - 1)) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end
                end
                STUFF: begin
                    run_d = '0;
                    if (bit_idx_q == IW'(DATA_W)) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign tx_active  = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_run_stuff_tx.sv
// Directed bench for run_stuff_tx: frame bit streams, stuffing, back-to-back, slow bit_en, async reset.
module tb_run_stuff_tx;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned PRE_ONES = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              bit_en = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              tx_bit;
    logic              tx_active;
    logic              frame_done;

    int checks   = 0;
    int failures = 0;
    int div      = 1;
    int ph       = 0;

    run_stuff_tx #(.DATA_W(DATA_W), .PRE_ONES(PRE_ONES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx_bit     (tx_bit),
        .tx_active  (tx_active),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Advance one clock; bit_en is high on every div-th edge; sampling point is 2 units after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        ph     = (ph + 1) % div;
        bit_en = (ph == 0);
        #1;
    endtask

    // Hand over one word, then compare every clock of the frame against exp (first bit = exp[len-1])
    task automatic send_frame(input string name, input logic [DATA_W-1:0] data,
                              input logic [31:0] exp, input int len, output int waited);
        in_data  = data;
        in_valid = 1'b1;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 200) begin
            checks++;
            if (in_ready !== bit_en || tx_active !== 1'b0) begin
                failures++;
                $display("FAIL %s idle_ready in_ready=%b bit_en=%b tx_active=%b", name, in_ready, bit_en, tx_active);
            end
            tick();
            waited++;
        end
        checks++;
        if (waited >= 200) begin
            failures++;
            $display("FAIL %s handshake_timeout waited=%0d required<200", name, waited);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        in_data  = ~data;
        for (int k = 0; k < len * div; k++) begin
            checks++;
            if (tx_bit !== exp[len - 1 - k / div]) begin
                failures++;
                $display("FAIL %s tx_bit clk=%0d got=%b exp=%b", name, k, tx_bit, exp[len - 1 - k / div]);
            end
            checks++;
            if (tx_active !== 1'b1 || frame_done !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s in_frame_flags clk=%0d active=%b done=%b ready=%b exp=1/0/0",
                         name, k, tx_active, frame_done, in_ready);
            end
            tick();
        end
        checks++;
        if (tx_bit !== 1'b0 || tx_active !== 1'b0 || frame_done !== 1'b1) begin
            failures++;
            $display("FAIL %s frame_end bit=%b active=%b done=%b exp=0/0/1", name, tx_bit, tx_active, frame_done);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        bit_en = 1'b1;
        #3;
        checks++;
        if (tx_bit !== 1'b0 || tx_active !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_values bit=%b active=%b done=%b exp=0/0/0", tx_bit, tx_active, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (tx_bit !== 1'b0 || tx_active !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_reset clk=%0d bit=%b active=%b ready=%b done=%b exp=0/0/1/0",
                         i, tx_bit, tx_active, in_ready, frame_done);
            end
        end
    endtask

    task automatic test_zero();
        int w;
        send_frame("zero", 8'h00, 32'(12'b1110_0000_0000), 12, w);
        tick();
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_pulse_width got=%b exp=0", frame_done);
        end
    endtask

    task automatic test_all_ones();
        int w;
        send_frame("all_ones", 8'hFF, 32'(16'b1110_110_110_110_110), 16, w);
        tick();
    endtask

    task automatic test_back_to_back();
        int w;
        send_frame("b6", 8'hB6, 32'(14'b1110_0110011001), 14, w);
        send_frame("b2b_01", 8'h01, 32'(12'b1110_1000_0000), 12, w);
        checks++;
        if (w != 0) begin
            failures++;
            $display("FAIL b2b_gap extra_idle_clks=%0d exp=0", w);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_pulse_width got=%b exp=0", frame_done);
        end
    endtask

    task automatic test_slow_bit_en();
        int w;
        div = 4;
        while (bit_en !== 1'b0) tick();
        in_valid = 1'b1;
        in_data  = 8'h3C;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL slow_ready_gap got=%b exp=0", in_ready);
        end
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (tx_active !== 1'b0 || tx_bit !== 1'b0) begin
            failures++;
            $display("FAIL slow_valid_drop active=%b bit=%b exp=0/0", tx_active, tx_bit);
        end
        send_frame("slow_a5", 8'hA5, 32'(12'b1110_1010_0101), 12, w);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (frame_done !== 1'b0 || in_ready !== bit_en || tx_bit !== 1'b0) begin
                failures++;
                $display("FAIL slow_idle clk=%0d done=%b ready=%b bit_en=%b bit=%b", i, frame_done, in_ready, bit_en, tx_bit);
            end
        end
        div = 1;
        tick();
    endtask

    task automatic test_reset_mid_frame();
        int w;
        in_data  = 8'hFF;
        in_valid = 1'b1;
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (tx_bit !== 1'b1 || tx_active !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_bit3 bit=%b active=%b exp=1/1", tx_bit, tx_active);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_bit !== 1'b0 || tx_active !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL async_abort bit=%b active=%b done=%b exp=0/0/0", tx_bit, tx_active, frame_done);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (frame_done !== 1'b0 || tx_active !== 1'b0) begin
                failures++;
                $display("FAIL post_abort clk=%0d done=%b active=%b exp=0/0", i, frame_done, tx_active);
            end
        end
        send_frame("after_abort", 8'h00, 32'(12'b1110_0000_0000), 12, w);
        tick();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_all_ones();
        test_back_to_back();
        test_slow_bit_en();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
